serial_mem_writer: RTL
======================

SERIAL_MEM_WRITER -- requirements
Module: serial_mem_writer

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock for all sequential logic.
REQ-002 SHALL have port CLR  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port START  input  1  begin a 16-byte capture; sampled on CLK.
REQ-004 SHALL have port X  input  1  serial data, MSB-first, one bit per CLK while busy.
REQ-005 SHALL have port RD_ADDR  input  4  read address of the storage array.
REQ-006 SHALL have port RD_DATA  output  8  combinational contents of the addressed entry.
REQ-007 SHALL have port WR_ADDR  output  4  address of the byte currently being assembled.
REQ-008 SHALL have port BUSY  output  1  high while in SHIFT.
REQ-009 SHALL have port BYTE_VALID  output  1  one-cycle pulse after each byte write.
REQ-010 SHALL have port G  output  1  done flag: all 16 bytes written.
REQ-011 SHALL have port Z  output  1  sticky pattern-mismatch flag.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 IDLE: START=1 at an edge SHALL enter SHIFT with WR_ADDR=0, bit count=0, Z=0 and G=0.
REQ-014 SHIFT: each edge SHALL shift X into an 8-bit register MSB-first and increment a 3-bit bit count.
REQ-015 At bit count 7 the edge SHALL write {shreg[6:0],X} to mem[WR_ADDR], clear the bit count and increment WR_ADDR.
REQ-016 BYTE_VALID SHALL be high exactly for the cycle following each write edge.
REQ-017 The write of byte 15 SHALL take the FSM to DONE, wrap WR_ADDR to 0 and set G.
REQ-018 Timing: with START sampled at edge k, byte n SHALL consist of the X bits sampled at edges k+8n+1 through k+8n+8; G SHALL rise after edge k+128.
REQ-019 START in SHIFT SHALL be ignored, with no restart and no state change.
REQ-020 DONE SHALL hold G=1; START=1 in DONE SHALL behave as in IDLE (REQ-013).
REQ-021 RD_DATA SHALL equal mem[RD_ADDR] combinationally; a same-cycle read of the address being written SHALL return the old value until the edge.
REQ-022 Storage SHALL be 16x8 and SHALL not be cleared by CLR or START; unwritten entries are X in simulation.

Reset
REQ-023 CLR SHALL asynchronously force IDLE with WR_ADDR=0, BUSY=0, BYTE_VALID=0, G=0, Z=0 and the shift register and bit count at 0.
REQ-024 CLR mid-SHIFT SHALL abandon the partial byte and leave already-written entries intact.

Configuration
REQ-025 Macro SERIAL_MEM_WRITER_PATCHK_EN SHALL compile the pattern check in or out.
REQ-026 With the macro: at each write, Z SHALL set if the byte differs from the expected value (8'hCC for an even address, 8'hAA for an odd address); Z SHALL stay sticky until START is accepted or CLR is asserted.
REQ-027 Without the macro: Z SHALL be tied to 0 and no comparator logic SHALL exist.

Structure
REQ-028 Package serial_mem_writer_pkg SHALL hold the state enum, DEPTH=16, WIDTH=8, PAT_EVEN=8'hCC and PAT_ODD=8'hAA.
REQ-029 The storage SHALL be a sub-module mem_16x8 with a synchronous write port and an asynchronous read port.

Verification
REQ-030 Bench: START pulse, then 128 bits of alternating CC/AA bytes -> 16 BYTE_VALID pulses 8 cycles apart; G=1 after edge k+128; Z=0; RD_DATA at addresses 0..15 reads CC, AA, CC, ...
REQ-031 Bench: same stream but byte 5 = 8'h00, macro on -> Z rises in the cycle after byte 5 is written, stays 1 through DONE, and clears on the next START; macro off -> Z stays 0.
REQ-032 Bench: CLR asserted after 43 bits -> all outputs 0 immediately, with no clock edge needed; entries 0..4 retain their values; a new START restarts at WR_ADDR=0.
REQ-033 Bench: START re-pulsed at bit 20 of SHIFT -> ignored; byte alignment and the G timing are unchanged.
REQ-034 Bench: START in DONE -> G drops, WR_ADDR=0, and the new stream overwrites entry 0 on the 8th edge.
REQ-035 Bench: RD_ADDR = WR_ADDR during the write edge -> RD_DATA shows the old value before the edge and the new value after it.

Source files
------------

// File: rtl/serial_mem_writer_pkg.sv
// Shared types and constants for the serial byte capture block.
package serial_mem_writer_pkg;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned CW    = 3;

    localparam logic [WIDTH-1:0] PAT_EVEN = 8'hCC;
    localparam logic [WIDTH-1:0] PAT_ODD  = 8'hAA;
    localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Reference byte for the pattern check, selected by address parity.
    function automatic logic [WIDTH-1:0] expected_byte(input logic odd);
        return odd ? PAT_ODD : PAT_EVEN;
    endfunction

endpackage

// File: rtl/serial_mem_writer_if.sv
// Control/data bundle between the capture block and its driver.
import serial_mem_writer_pkg::*;

interface serial_mem_writer_if;
    logic             START;
    logic             X;
    logic [AW-1:0]    RD_ADDR;
    logic [WIDTH-1:0] RD_DATA;
    logic [AW-1:0]    WR_ADDR;
    logic             BUSY;
    logic             BYTE_VALID;
    logic             G;
    logic             Z;

    modport master (
        output START, X, RD_ADDR,
        input  RD_DATA, WR_ADDR, BUSY, BYTE_VALID, G, Z
    );

    modport slave (
        input  START, X, RD_ADDR,
        output RD_DATA, WR_ADDR, BUSY, BYTE_VALID, G, Z
    );
endinterface

// File: rtl/serial_mem_writer_mem.sv
// 16x8 storage: synchronous write, asynchronous read, never cleared.
module mem_16x8
    import serial_mem_writer_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; a same-cycle read sees the old value until this edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/serial_mem_writer.sv
// Captures 16 MSB-first serial bytes into a 16x8 store.
// Optional pattern check (Z flag) is compiled in by SERIAL_MEM_WRITER_PATCHK_EN.
module serial_mem_writer
    import serial_mem_writer_pkg::*;
(
    input  logic                CLK,
    input  logic                CLR,
    serial_mem_writer_if.slave  bus
);

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    // Only the 7 bits preceding the current X ever reach memory.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic             busy_q;
    logic             byte_valid_q, byte_valid_d;
    logic             g_q, g_d;
    logic             we_c;
    logic [WIDTH-1:0] wdata_c;
`ifdef SERIAL_MEM_WRITER_PATCHK_EN
    logic             z_q, z_d;
`endif

    // Next-state and datapath updates for the capture FSM.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        g_d          = g_q;
        we_c         = 1'b0;
        wdata_c      = {shreg_q, bus.X};
`ifdef SERIAL_MEM_WRITER_PATCHK_EN
        z_d          = z_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.START) begin
                    state_d   = SHIFT;
                    wr_addr_d = '0;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    g_d       = 1'b0;
`ifdef SERIAL_MEM_WRITER_PATCHK_EN
                    z_d       = 1'b0;
`endif
                end
            end
            SHIFT: begin
                shreg_d   = {shreg_q[WIDTH-3:0], bus.X};
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    we_c         = 1'b1;
                    byte_valid_d = 1'b1;
                    wr_addr_d    = wr_addr_q + AW'(1);
`ifdef SERIAL_MEM_WRITER_PATCHK_EN
                    z_d = z_q | (wdata_c != expected_byte(wr_addr_q[0]));
`endif
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                        g_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; CLR abandons any partial byte.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            busy_q       <= 1'b0;
            byte_valid_q <= 1'b0;
            g_q          <= 1'b0;
`ifdef SERIAL_MEM_WRITER_PATCHK_EN
            z_q          <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            busy_q       <= (state_d == SHIFT);
            byte_valid_q <= byte_valid_d;
            g_q          <= g_d;
`ifdef SERIAL_MEM_WRITER_PATCHK_EN
            z_q          <= z_d;
`endif
        end
    end

    mem_16x8 u_mem (
        .clk   (CLK),
        .we    (we_c),
        .waddr (wr_addr_q),
        .wdata (wdata_c),
        .raddr (bus.RD_ADDR),
        .rdata (bus.RD_DATA)
    );

    assign bus.WR_ADDR    = wr_addr_q;
    assign bus.BUSY       = busy_q;
    assign bus.BYTE_VALID = byte_valid_q;
    assign bus.G          = g_q;
`ifdef SERIAL_MEM_WRITER_PATCHK_EN
    assign bus.Z          = z_q;
`else
    assign bus.Z          = 1'b0;
`endif

endmodule
